mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/mem_stage_lsu.sv | 99 +++++++++
 tb/tb_mem_stage_lsu.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory stage with give/get handshakes to EX and WB and a single-request load/store bus port.
module mem_stage_lsu #(
  parameter int BITSIZE = 32
) (
  input  logic               clk,
  input  logic               rst_i,
  output logic               MEM_EX_get_o,
  input  logic               EX_MEM_give_i,
  input  logic [31:0]        EX_MEM_instruction_i,
  input  logic [BITSIZE-1:0] EX_MEM_data_i,
  input  logic [BITSIZE-1:0] EX_MEM_store_data_i,
  output logic               MEM_bus_req_o,
  output logic               MEM_bus_we_o,
  output logic [31:0]        MEM_bus_addr_o,
  output logic [3:0]         MEM_bus_be_o,
  output logic [31:0]        MEM_bus_wdata_o,
  input  logic               MEM_bus_ack_i,
  input  logic [31:0]        MEM_bus_rdata_i,
  input  logic               WB_MEM_get_i,
  output logic               MEM_WB_give_o,
  output logic [31:0]        MEM_WB_instruction_o,
  output logic [BITSIZE-1:0] MEM_WB_data_o,
  output logic               MEM_misaligned_o
);
  typedef enum logic [1:0] {S_GET, S_BUS, S_GIVE} state_t;
  state_t             r_state;
  logic [31:0]        r_instr, r_addr, r_wdata;
  logic [BITSIZE-1:0] r_result;
  logic [3:0]         r_be;
  logic [2:0]         r_f3;
  logic [1:0]         r_a;
  logic               r_we, r_mis, r_load;
  logic [2:0]         w_f3;
  logic [1:0]         w_a;
  logic               w_ld, w_st, w_mem, w_byte, w_half, w_aligned;
  logic [15:0]        w_lane;
  logic [31:0]        w_ldv;
  assign w_f3      = EX_MEM_instruction_i[14:12];
  assign w_a       = EX_MEM_data_i[1:0];
  assign w_ld      = EX_MEM_instruction_i[6:0] == 7'b0000011;
  assign w_st      = EX_MEM_instruction_i[6:0] == 7'b0100011;
  assign w_mem     = w_ld | w_st;
  // unsigned load widths only exist for loads; stores fall back to word
  assign w_byte    = (w_f3 == 3'b000) | (w_ld & (w_f3 == 3'b100));
  assign w_half    = (w_f3 == 3'b001) | (w_ld & (w_f3 == 3'b101));
  assign w_aligned = w_byte | (w_half ? ~w_a[0] : (w_a == 2'b00));
  assign w_lane    = 16'(MEM_bus_rdata_i >> {r_a, 3'b000});
  assign w_ldv     = (r_f3 == 3'b000) ? {{24{w_lane[7]}}, w_lane[7:0]} :
                     (r_f3 == 3'b001) ? {{16{w_lane[15]}}, w_lane[15:0]} :
                     (r_f3 == 3'b100) ? {24'h0, w_lane[7:0]} :
                     (r_f3 == 3'b101) ? {16'h0, w_lane[15:0]} : MEM_bus_rdata_i;
  assign MEM_EX_get_o         = r_state == S_GET;
  assign MEM_bus_req_o        = r_state == S_BUS;
  assign MEM_bus_we_o         = MEM_bus_req_o & r_we;
  assign MEM_bus_be_o         = MEM_bus_req_o ? r_be : 4'b0000;
  assign MEM_bus_addr_o       = r_addr;
  assign MEM_bus_wdata_o      = r_wdata;
  assign MEM_WB_give_o        = r_state == S_GIVE;
  assign MEM_WB_instruction_o = r_instr;
  assign MEM_WB_data_o        = r_result;
  assign MEM_misaligned_o     = r_mis;
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_GET;
      r_instr  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_result <= '0;
      r_be     <= '0;
      r_f3     <= '0;
      r_a      <= '0;
      r_we     <= 1'b0;
      r_mis    <= 1'b0;
      r_load   <= 1'b0;
    end else begin
      r_mis <= 1'b0;
      case (r_state)
        S_GET: if (EX_MEM_give_i) begin
          r_instr  <= EX_MEM_instruction_i;
          r_a      <= w_a;
          r_f3     <= w_f3;
          r_load   <= w_ld;
          r_we     <= w_st;
          r_addr   <= {EX_MEM_data_i[31:2], 2'b00};
          r_be     <= w_byte ? 4'b0001 << w_a : w_half ? 4'b0011 << w_a : 4'b1111;
          r_wdata  <= (w_byte | w_half) ? EX_MEM_store_data_i << {w_a, 3'b000} : EX_MEM_store_data_i;
          r_result <= w_mem ? '0 : EX_MEM_data_i;
          r_mis    <= w_mem & ~w_aligned;
          r_state  <= (w_mem & w_aligned) ? S_BUS : S_GIVE;
        end
        S_BUS: if (MEM_bus_ack_i) begin
          r_result <= r_load ? w_ldv : '0;
          r_state  <= S_GIVE;
        end
        default: if (WB_MEM_get_i) r_state <= S_GET;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: vector table of EX transactions with a writeback scoreboard, plus reset-during-bus sequence.
module tb_mem_stage_lsu;
  logic        clk = 0, rst_i = 1;
  logic        get_o, give_i = 0, req, we, ack = 0, wb_get = 0, give_o, mis;
  logic [31:0] instr = 0, data = 0, sdata = 0, addr, wdata, rdata = 0, wb_instr, wb_data;
  logic [3:0]  be;
  int          n_tests = 0, n_fail = 0;
  logic [31:0] sb_data[$], sb_instr[$];
  typedef struct {
    logic [31:0] instr, data, sdata, rdata;
    int          ack_dly, wb_dly;
    logic [31:0] e_mis, e_req, e_we, e_be, e_addr, e_wdata, e_data;
  } vec_t;
  vec_t vecs[13];
  mem_stage_lsu #(.BITSIZE(32)) dut (
    .clk(clk), .rst_i(rst_i), .MEM_EX_get_o(get_o), .EX_MEM_give_i(give_i),
    .EX_MEM_instruction_i(instr), .EX_MEM_data_i(data), .EX_MEM_store_data_i(sdata),
    .MEM_bus_req_o(req), .MEM_bus_we_o(we), .MEM_bus_addr_o(addr), .MEM_bus_be_o(be),
    .MEM_bus_wdata_o(wdata), .MEM_bus_ack_i(ack), .MEM_bus_rdata_i(rdata),
    .WB_MEM_get_i(wb_get), .MEM_WB_give_o(give_o), .MEM_WB_instruction_o(wb_instr),
    .MEM_WB_data_o(wb_data), .MEM_misaligned_o(mis)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [31:0] i, d, s, r, input int ad, wd,
                              input logic [31:0] m, q, w, b, a, wdt, res);
    vec_t v;
    v.instr = i; v.data = d; v.sdata = s; v.rdata = r; v.ack_dly = ad; v.wb_dly = wd;
    v.e_mis = m; v.e_req = q; v.e_we = w; v.e_be = b; v.e_addr = a; v.e_wdata = wdt; v.e_data = res;
    return v;
  endfunction
  task automatic do_vec(input vec_t v);
    chk("get_ready", get_o, 1);
    give_i = 1; instr = v.instr; data = v.data; sdata = v.sdata; wb_get = 0;
    @(posedge clk); #1;
    give_i = 0; instr = $urandom; data = $urandom; sdata = $urandom;
    sb_data.push_back(v.e_data); sb_instr.push_back(v.instr);
    chk("get_low", get_o, 0);
    chk("misaligned", mis, v.e_mis);
    chk("req", req, v.e_req);
    if (v.e_req) begin
      chk("we", we, v.e_we);
      chk("be", be, v.e_be);
      chk("addr", addr, v.e_addr);
      if (v.e_we) chk("wdata", wdata, v.e_wdata);
      for (int k = 0; k < v.ack_dly; k++) begin
        @(posedge clk); #1;
        chk("req_hold", req, 1);
        chk("addr_hold", addr, v.e_addr);
        chk("be_hold", be, v.e_be);
        chk("give_early", give_o, 0);
      end
      ack = 1; rdata = v.rdata;
      @(posedge clk); #1;
      ack = 0; rdata = $urandom;
    end
    chk("give", give_o, 1);
    chk("req_off", req, 0);
    chk("be_off", be, 0);
    for (int k = 0; k < v.wb_dly; k++) begin
      @(posedge clk); #1;
      chk("give_hold", give_o, 1);
      chk("data_hold", wb_data, sb_data[0]);
      chk("get_blocked", get_o, 0);
    end
    chk("wb_data", wb_data, sb_data.pop_front());
    chk("wb_instr", wb_instr, sb_instr.pop_front());
    wb_get = 1;
    @(posedge clk); #1;
    wb_get = 0;
    chk("back_to_get", get_o, 1);
    chk("give_done", give_o, 0);
    chk("mis_pulse_end", mis, 0);
  endtask
  initial begin
    vecs[0]  = mk(32'h00500093, 32'h5,        0,            0,            0, 0, 0, 0, 0, 0,       0,        0,            32'h5);
    vecs[1]  = mk(32'h00000083, 32'h103,      0,            32'h80FFFF7F, 0, 0, 0, 1, 0, 4'b1000, 32'h100,  0,            32'hFFFFFF80);
    vecs[2]  = mk(32'h00001023, 32'h202,      32'h1234ABCD, 0,            0, 0, 0, 1, 1, 4'b1100, 32'h200,  32'hABCD0000, 0);
    vecs[3]  = mk(32'h00002083, 32'h6,        0,            0,            0, 0, 1, 0, 0, 0,       0,        0,            0);
    vecs[4]  = mk(32'h00005083, 32'h10,       0,            32'hDEAD8765, 3, 2, 0, 1, 0, 4'b0011, 32'h10,   0,            32'h00008765);
    vecs[5]  = mk(32'h00004083, 32'h101,      0,            32'h11229933, 0, 0, 0, 1, 0, 4'b0010, 32'h100,  0,            32'h00000099);
    vecs[6]  = mk(32'h00001083, 32'h12,       0,            32'h80010000, 1, 1, 0, 1, 0, 4'b1100, 32'h10,   0,            32'hFFFF8001);
    vecs[7]  = mk(32'h00000023, 32'h301,      32'h000000A5, 0,            0, 0, 0, 1, 1, 4'b0010, 32'h300,  32'h0000A500, 0);
    vecs[8]  = mk(32'h00002023, 32'h400,      32'hCAFEBABE, 0,            2, 0, 0, 1, 1, 4'b1111, 32'h400,  32'hCAFEBABE, 0);
    vecs[9]  = mk(32'h00001023, 32'h203,      32'h55555555, 0,            0, 0, 1, 0, 0, 0,       0,        0,            0);
    vecs[10] = mk(32'h00003083, 32'h20,       0,            32'h01234567, 0, 0, 0, 1, 0, 4'b1111, 32'h20,   0,            32'h01234567);
    vecs[11] = mk(32'h00001083, 32'h11,       0,            0,            0, 0, 1, 0, 0, 0,       0,        0,            0);
    vecs[12] = mk(32'h000000B7, 32'hDEADBEEF, 0,            0,            0, 1, 0, 0, 0, 0,       0,        0,            32'hDEADBEEF);
    #2;
    chk("rst_get", get_o, 1);
    chk("rst_give", give_o, 0);
    chk("rst_req", req, 0);
    chk("rst_be", be, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_instr", wb_instr, 0);
    chk("rst_mis", mis, 0);
    @(posedge clk); #1;
    rst_i = 0;
    foreach (vecs[i]) do_vec(vecs[i]);
    give_i = 1; instr = 32'h00002083; data = 32'h40;
    @(posedge clk); #1;
    give_i = 0;
    chk("pre_rst_req", req, 1);
    #2 rst_i = 1;
    #1;
    chk("rst_req_drop", req, 0);
    chk("rst_get_now", get_o, 1);
    #1 rst_i = 0;
    ack = 1; rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    ack = 0;
    chk("late_ack_give", give_o, 0);
    chk("late_ack_get", get_o, 1);
    chk("late_ack_req", req, 0);
    chk("late_ack_data", wb_data, 0);
    do_vec(vecs[0]);
    chk("sb_empty", sb_data.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
